// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Used by fetch and the stages downstream of it.
package mips_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JREG   = 2'd3
  } pc_src_t;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pcPlus4;
    logic [31:0] instruction;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready handshake.
// The fetch stage is master; the memory is slave.
interface fetch_stage_if;

  logic [31:0] imemAddress;
  logic        imemRequest;
  logic        imemReady;
  logic [31:0] imemData;

  modport master (
    output imemAddress,
    output imemRequest,
    input  imemReady,
    input  imemData
  );

  modport slave (
    input  imemAddress,
    input  imemRequest,
    output imemReady,
    output imemData
  );

endinterface

// File: rtl/fetch_stage_next_pc.sv
// Next-PC target mux, PC+4 adder and jump-target concatenation.
// Purely combinational.
module next_pc_select
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  pc_src_t     src,
  input  logic [31:0] branchTarget,
  input  logic [25:0] jumpIndex,
  input  logic [31:0] jumpRegister,
  input  logic [31:0] ifIdPcPlus4,
  output logic [31:0] pcPlus4,
  output logic [31:0] target,
  output logic        redirect
);

  logic [31:0] jumpTarget;

  assign pcPlus4    = pc + 32'd4;
  assign jumpTarget = {ifIdPcPlus4[31:28],
                       jumpIndex, 2'b00};
  assign redirect   = (src != PC_PLUS4);

  always_comb begin
    target = pcPlus4;
    unique case (src)
      PC_PLUS4:  target = pcPlus4;
      PC_BRANCH: target = branchTarget;
      PC_JUMP:   target = jumpTarget;
      PC_JREG:   target = jumpRegister;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, next-PC select,
// imem handshake and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic [1:0]    pcSrc,
  input  logic [31:0]   branchTarget,
  input  logic [25:0]   jumpIndex,
  input  logic [31:0]   jumpRegister,
  fetch_stage_if.master imem,
  output logic [31:0]   ifIdPcPlus4,
  output logic [31:0]   ifIdInstruction,
  output logic          ifIdValid
);

  import mips_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_q, redir_d;
  if_id_t       ifid_q, ifid_d;

  pc_src_t      src;
  logic [31:0]  pcPlus4;
  logic [31:0]  target;
  logic         redirect;
  logic         ready;

  assign src   = pc_src_t'(pcSrc);
  assign ready = imem.imemReady;

  next_pc_select u_next_pc (
    .pc           (pc_q),
    .src          (src),
    .branchTarget (branchTarget),
    .jumpIndex    (jumpIndex),
    .jumpRegister (jumpRegister),
    .ifIdPcPlus4  (ifid_q.pcPlus4),
    .pcPlus4      (pcPlus4),
    .target       (target),
    .redirect     (redirect)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      redir_q <= 32'h0;
      ifid_q  <= '{32'h0, NOP_INSTR, 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      ifid_q  <= ifid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    ifid_d  = ifid_q;
    unique case (state_q)
      FETCH: begin
        if (redirect && ready) begin
          pc_d = target;
        end else if (redirect) begin
          redir_d = target;
          state_d = DISCARD;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (ready) begin
          pc_d   = pcPlus4;
          ifid_d = '{pcPlus4, imem.imemData, 1'b1};
        end
      end
      DISCARD: begin
        // Latest redirect wins over the parked one
        if (redirect) begin
          redir_d = target;
        end
        if (ready) begin
          pc_d    = redirect ? target : redir_q;
          state_d = FETCH;
        end
      end
    endcase
    if (flush) begin
      ifid_d = '{32'h0, NOP_INSTR, 1'b0};
    end
  end

  assign imem.imemAddress = pc_q;
  assign imem.imemRequest = reset;
  assign ifIdPcPlus4      = ifid_q.pcPlus4;
  assign ifIdInstruction  = ifid_q.instruction;
  assign ifIdValid        = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage.
// Vectors are applied in order from reset release.
module tb_fetch_stage;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [1:0]  src;
    logic [31:0] bt;
    logic [25:0] ji;
    logic [31:0] jr;
    logic        rdy;
    logic [31:0] data;
    logic [31:0] e_addr;
    logic [31:0] e_pp4;
    logic [31:0] e_ins;
    logic        e_val;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [1:0]  pcSrc;
  logic [31:0] branchTarget;
  logic [25:0] jumpIndex;
  logic [31:0] jumpRegister;
  logic [31:0] ifIdPcPlus4;
  logic [31:0] ifIdInstruction;
  logic        ifIdValid;

  int tests;
  int fails;

  fetch_stage_if imem ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .pcSrc           (pcSrc),
    .branchTarget    (branchTarget),
    .jumpIndex       (jumpIndex),
    .jumpRegister    (jumpRegister),
    .imem            (imem.master),
    .ifIdPcPlus4     (ifIdPcPlus4),
    .ifIdInstruction (ifIdInstruction),
    .ifIdValid       (ifIdValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall            = v.stall;
    flush            = v.flush;
    pcSrc            = v.src;
    branchTarget     = v.bt;
    jumpIndex        = v.ji;
    jumpRegister     = v.jr;
    imem.imemReady   = v.rdy;
    imem.imemData    = v.data;
  endtask

  task automatic check(input string tag,
                       input vec_t v);
    chk({tag, " addr"}, imem.imemAddress, v.e_addr);
    chk({tag, " req"}, {31'h0, imem.imemRequest},
        32'h1);
    chk({tag, " pp4"}, ifIdPcPlus4, v.e_pp4);
    chk({tag, " ins"}, ifIdInstruction, v.e_ins);
    chk({tag, " val"}, {31'h0, ifIdValid},
        {31'h0, v.e_val});
  endtask

  function automatic vec_t mk(
    input logic s, input logic f,
    input logic [1:0] src, input logic [31:0] bt,
    input logic [25:0] ji, input logic [31:0] jr,
    input logic r, input logic [31:0] d,
    input logic [31:0] ea, input logic [31:0] ep,
    input logic [31:0] ei, input logic ev);
    vec_t v;
    v.stall = s;  v.flush = f;  v.src = src;
    v.bt = bt;    v.ji = ji;    v.jr = jr;
    v.rdy = r;    v.data = d;
    v.e_addr = ea; v.e_pp4 = ep;
    v.e_ins = ei;  v.e_val = ev;
    return v;
  endfunction

  vec_t tbl [24];

  initial begin
    tests = 0;
    fails = 0;
    // s f src bt ji jr rdy data | addr pp4 ins val
    tbl[0]  = mk(0,0,0,0,0,0,1,32'h2008_0005,
                 32'h4,32'h4,32'h2008_0005,1);
    tbl[1]  = mk(0,0,0,0,0,0,1,32'h2008_0005,
                 32'h8,32'h8,32'h2008_0005,1);
    tbl[2]  = mk(1,0,0,0,0,0,1,32'hDEAD_0001,
                 32'h8,32'h8,32'h2008_0005,1);
    tbl[3]  = mk(1,0,0,0,0,0,1,32'hDEAD_0002,
                 32'h8,32'h8,32'h2008_0005,1);
    tbl[4]  = mk(0,0,0,0,0,0,1,32'h1111_1111,
                 32'hC,32'hC,32'h1111_1111,1);
    tbl[5]  = mk(0,0,0,0,0,0,1,32'h2222_2222,
                 32'h10,32'h10,32'h2222_2222,1);
    tbl[6]  = mk(0,1,1,32'h40,0,0,1,32'hBAD0_0006,
                 32'h40,32'h0,32'h0,0);
    tbl[7]  = mk(0,0,0,0,0,0,1,32'h3333_3333,
                 32'h44,32'h44,32'h3333_3333,1);
    tbl[8]  = mk(0,1,3,0,0,32'hA000_000C,1,32'hBAD0_0008,
                 32'hA000_000C,32'h0,32'h0,0);
    tbl[9]  = mk(0,0,0,0,0,0,1,32'h0800_0100,
                 32'hA000_0010,32'hA000_0010,
                 32'h0800_0100,1);
    tbl[10] = mk(0,0,2,0,26'h000_0100,0,1,32'hBAD0_000A,
                 32'hA000_0400,32'hA000_0010,
                 32'h0800_0100,1);
    tbl[11] = mk(0,0,0,0,0,0,0,32'hBAD0_000B,
                 32'hA000_0400,32'hA000_0010,
                 32'h0800_0100,1);
    tbl[12] = mk(0,0,3,0,0,32'h80,0,32'hBAD0_000C,
                 32'hA000_0400,32'hA000_0010,
                 32'h0800_0100,1);
    tbl[13] = mk(0,0,3,0,0,32'h90,0,32'hBAD0_000D,
                 32'hA000_0400,32'hA000_0010,
                 32'h0800_0100,1);
    tbl[14] = mk(0,0,0,0,0,0,1,32'h4444_4444,
                 32'h90,32'hA000_0010,
                 32'h0800_0100,1);
    tbl[15] = mk(0,0,0,0,0,0,1,32'h5555_5555,
                 32'h94,32'h94,32'h5555_5555,1);
    tbl[16] = mk(1,0,1,32'h100,0,0,1,32'hBAD0_0010,
                 32'h100,32'h94,32'h5555_5555,1);
    tbl[17] = mk(0,1,0,0,0,0,0,32'hBAD0_0011,
                 32'h100,32'h0,32'h0,0);
    tbl[18] = mk(0,1,0,0,0,0,1,32'hBAD0_0012,
                 32'h104,32'h0,32'h0,0);
    tbl[19] = mk(0,0,3,0,0,32'hFFFF_FFFC,1,32'hBAD0_0013,
                 32'hFFFF_FFFC,32'h0,32'h0,0);
    tbl[20] = mk(0,0,0,0,0,0,1,32'h6666_6666,
                 32'h0,32'h0,32'h6666_6666,1);
    tbl[21] = mk(0,0,1,32'h300,0,0,0,32'hBAD0_0015,
                 32'h0,32'h0,32'h6666_6666,1);
    tbl[22] = mk(0,0,1,32'h340,0,0,1,32'hBAD0_0016,
                 32'h340,32'h0,32'h6666_6666,1);
    tbl[23] = mk(0,0,0,0,0,0,1,32'h7777_7777,
                 32'h344,32'h344,32'h7777_7777,1);

    reset = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    #12;
    chk("rst addr", imem.imemAddress, 32'h0);
    chk("rst req", {31'h0, imem.imemRequest}, 32'h0);
    chk("rst pp4", ifIdPcPlus4, 32'h0);
    chk("rst ins", ifIdInstruction, 32'h0);
    chk("rst val", {31'h0, ifIdValid}, 32'h0);

    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i]);
      @(posedge clock);
      @(negedge clock);
      check($sformatf("v%0d", i), tbl[i]);
    end

    // Reset asserted while a redirect waits in DISCARD
    drive(mk(0,0,1,32'h200,0,0,0,32'hBAD0_0020,
             0,0,0,0));
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("mid addr", imem.imemAddress, 32'h0);
    chk("mid req", {31'h0, imem.imemRequest}, 32'h0);
    chk("mid pp4", ifIdPcPlus4, 32'h0);
    chk("mid ins", ifIdInstruction, 32'h0);
    chk("mid val", {31'h0, ifIdValid}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    drive(mk(0,0,0,0,0,0,1,32'h1234_5678,
             32'h4,32'h4,32'h1234_5678,1));
    @(posedge clock);
    @(negedge clock);
    check("post", mk(0,0,0,0,0,0,1,32'h1234_5678,
                     32'h4,32'h4,32'h1234_5678,1));

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
